// File: rtl/xoodyak_cmd_feeder.sv
// Command FIFO and hold sequencer ahead of xoodyak_build: queues host commands,
// zero-masks data beyond the byte count, and holds each on opmode/input_data for HOLD_CYCLES.
module xoodyak_cmd_feeder #(
  parameter int          DEPTH       = 4,
  parameter int          HOLD_CYCLES = 4,
  parameter logic [4:0]  IDLE_OP     = 5'h00
) (
  input  logic                     eph1,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_hash,
  input  logic [3:0]               cmd_op,
  input  logic [5:0]               cmd_nbytes,
  input  logic [351:0]             cmd_data,
  input  logic                     flush,
  output logic [4:0]               opmode,
  output logic [351:0]             input_data,
  output logic                     issue_active,
  output logic                     issue_last,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int EW = 5 + 352;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  // Keep byte i (byte 0 = MSB) only when i < min(nbytes, 44).
  function automatic logic [351:0] mask_data(input logic [351:0] d, input logic [5:0] n);
    logic [5:0]   ns;
    logic [351:0] m;
    ns = (n > 6'd44) ? 6'd44 : n;
    m  = '0;
    for (int i = 0; i < 44; i++) begin
      if (i < int'(ns)) m[351-8*i -: 8] = 8'hFF;
    end
    return d & m;
  endfunction

  logic [EW-1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  state_t         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [4:0]     opmode_q, opmode_d;
  logic [351:0]   data_q, data_d;
  logic           push, pop;
  logic [EW-1:0]  head;

  assign cmd_ready = (count_q != CW'(DEPTH));
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    push     = cmd_valid & cmd_ready & ~flush;
    pop      = 1'b0;
    state_d  = state_q;
    hold_d   = hold_q;
    opmode_d = opmode_q;
    data_d   = data_q;
    if (flush) begin
      state_d  = S_IDLE;
      hold_d   = '0;
      opmode_d = IDLE_OP;
      data_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            pop      = 1'b1;
            state_d  = S_ISSUE;
            hold_d   = HOLD_INIT;
            opmode_d = head[EW-1 -: 5];
            data_d   = head[351:0];
          end
        end
        S_ISSUE: begin
          if (hold_q == '0) begin
            // Next command follows with no idle gap when one is queued.
            if (count_q != '0) begin
              pop      = 1'b1;
              hold_d   = HOLD_INIT;
              opmode_d = head[EW-1 -: 5];
              data_d   = head[351:0];
            end else begin
              state_d  = S_IDLE;
              opmode_d = IDLE_OP;
              data_d   = '0;
            end
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge eph1) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      opmode_q <= IDLE_OP;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      opmode_q <= opmode_d;
      data_q   <= data_d;
    end
  end

  // Storage is data-only; validity is tracked by the pointers and count.
  always_ff @(posedge eph1) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_hash, cmd_op, mask_data(cmd_data, cmd_nbytes)};
  end

  assign opmode       = opmode_q;
  assign input_data   = data_q;
  assign issue_active = (state_q == S_ISSUE);
  assign issue_last   = (state_q == S_ISSUE) && (hold_q == '0);
  assign fifo_count   = count_q;

endmodule
